// File: rtl/slot_c8_arbiter.sv
// Tracks which slot owns the shared $C800-$CFFF expansion ROM window and
// produces a per-slot I/O strobe that only the owning card sees.
module slot_c8_arbiter #(
  parameter logic [15:0] RELEASE_ADDR = 16'hCFFF
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        addr_strobe,
  input  logic [15:0] addr,
  input  logic        m2sel_n,
  input  logic        bus_reset,
  input  logic [2:0]  slot,
  input  logic [7:0]  card_id,
  input  logic        ioselect_n,
  input  logic        iostrobe_n,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_slot,
  output logic        owner_valid,
  output logic [2:0]  owner_slot,
  output logic [7:0]  owner_card,
  output logic [7:0]  c8_sel_n,
  output logic        claim_pulse,
  output logic        release_pulse
);

  logic        sample_q, sample_d;
  logic [15:0] addr_q, addr_d;
  logic        m2sel_n_q, m2sel_n_d;
  logic        owner_valid_q, owner_valid_d;
  logic [2:0]  owner_slot_q, owner_slot_d;
  logic [7:0]  owner_card_q, owner_card_d;
  logic [7:0]  c8_sel_n_q, c8_sel_n_d;
  logic        claim_q, claim_d;
  logic        release_q, release_d;

  logic        cfg_drop_s;
  logic        claim_ok_s;
  logic        rel_hit_s;

  // slot_if inputs lag the address by a cycle, so they only matter while sample_q is set
  always_comb begin
    sample_d      = addr_strobe;
    addr_d        = addr_strobe ? addr : addr_q;
    m2sel_n_d     = addr_strobe ? m2sel_n : m2sel_n_q;
    owner_valid_d = owner_valid_q;
    owner_slot_d  = owner_slot_q;
    owner_card_d  = owner_card_q;
    c8_sel_n_d    = c8_sel_n_q;
    claim_d       = 1'b0;
    release_d     = 1'b0;

    cfg_drop_s = cfg_wr && owner_valid_q && (cfg_slot == owner_slot_q);
    claim_ok_s = sample_q && !ioselect_n && (card_id != 8'h00)
                 && !(cfg_drop_s && (slot == cfg_slot));
    rel_hit_s  = sample_q && (addr_q == RELEASE_ADDR) && !m2sel_n_q;

    if (bus_reset) begin
      sample_d      = 1'b0;
      owner_valid_d = 1'b0;
      owner_slot_d  = 3'd0;
      owner_card_d  = 8'h00;
      c8_sel_n_d    = 8'hFF;
    end else begin
      // Strobe uses the owner as it stood before this cycle's claim/release
      if (sample_q) begin
        c8_sel_n_d = (owner_valid_q && !iostrobe_n) ? ~(8'h01 << owner_slot_q) : 8'hFF;
      end else begin
        c8_sel_n_d = c8_sel_n_q;
      end

      if (cfg_drop_s) begin
        owner_valid_d = 1'b0;
        owner_slot_d  = 3'd0;
        owner_card_d  = 8'h00;
        release_d     = 1'b1;
      end else begin
        owner_valid_d = owner_valid_q;
      end

      if (claim_ok_s) begin
        claim_d       = !owner_valid_d || (slot != owner_slot_q);
        owner_valid_d = 1'b1;
        owner_slot_d  = slot;
        owner_card_d  = card_id;
      end else if (rel_hit_s && owner_valid_d) begin
        owner_valid_d = 1'b0;
        owner_slot_d  = 3'd0;
        owner_card_d  = 8'h00;
        release_d     = 1'b1;
      end else begin
        claim_d = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sample_q      <= 1'b0;
      addr_q        <= 16'h0000;
      m2sel_n_q     <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_slot_q  <= 3'd0;
      owner_card_q  <= 8'h00;
      c8_sel_n_q    <= 8'hFF;
      claim_q       <= 1'b0;
      release_q     <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      addr_q        <= addr_d;
      m2sel_n_q     <= m2sel_n_d;
      owner_valid_q <= owner_valid_d;
      owner_slot_q  <= owner_slot_d;
      owner_card_q  <= owner_card_d;
      c8_sel_n_q    <= c8_sel_n_d;
      claim_q       <= claim_d;
      release_q     <= release_d;
    end
  end

  assign owner_valid   = owner_valid_q;
  assign owner_slot    = owner_slot_q;
  assign owner_card    = owner_card_q;
  assign c8_sel_n      = c8_sel_n_q;
  assign claim_pulse   = claim_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_slot_c8_arbiter.sv
// Self-checking bench for slot_c8_arbiter: directed vector table, hand-written
// reset/reconfigure sequences, and randomized traffic against an ownership model.
module tb_slot_c8_arbiter;

  logic        clk_logic = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        addr_strobe = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        m2sel_n = 1'b1;
  logic        bus_reset = 1'b0;
  logic [2:0]  slot = 3'd0;
  logic [7:0]  card_id = 8'h00;
  logic        ioselect_n = 1'b1;
  logic        iostrobe_n = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_slot = 3'd0;
  logic        owner_valid;
  logic [2:0]  owner_slot;
  logic [7:0]  owner_card;
  logic [7:0]  c8_sel_n;
  logic        claim_pulse;
  logic        release_pulse;

  int pass_cnt = 0;
  int total_cnt = 0;

  slot_c8_arbiter dut (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .addr_strobe(addr_strobe),
    .addr(addr), .m2sel_n(m2sel_n), .bus_reset(bus_reset), .slot(slot),
    .card_id(card_id), .ioselect_n(ioselect_n), .iostrobe_n(iostrobe_n),
    .cfg_wr(cfg_wr), .cfg_slot(cfg_slot), .owner_valid(owner_valid),
    .owner_slot(owner_slot), .owner_card(owner_card), .c8_sel_n(c8_sel_n),
    .claim_pulse(claim_pulse), .release_pulse(release_pulse)
  );

  always #5 clk_logic = ~clk_logic;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic        m2;
    logic [2:0]  s;
    logic [7:0]  c;
    logic        io;
    logic        ios;
    logic        ev;
    logic [2:0]  es;
    logic [7:0]  ec;
    logic [7:0]  esel;
    logic        ecl;
    logic        erl;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [2:0] es,
                         input logic [7:0] ec, input logic [7:0] esel,
                         input logic ecl, input logic erl);
    chk({tag, ".owner_valid"}, {31'd0, owner_valid}, {31'd0, ev});
    chk({tag, ".owner_slot"}, {29'd0, owner_slot}, {29'd0, es});
    chk({tag, ".owner_card"}, {24'd0, owner_card}, {24'd0, ec});
    chk({tag, ".c8_sel_n"}, {24'd0, c8_sel_n}, {24'd0, esel});
    chk({tag, ".claim_pulse"}, {31'd0, claim_pulse}, {31'd0, ecl});
    chk({tag, ".release_pulse"}, {31'd0, release_pulse}, {31'd0, erl});
  endtask

  task automatic idle_slot_if();
    ioselect_n = 1'b1;
    iostrobe_n = 1'b1;
    card_id    = 8'h00;
    slot       = 3'd0;
  endtask

  // One bus access: strobe at T, slot_if at T+1, returns at T+2 (+1 time unit)
  task automatic txn(input logic [15:0] a, input logic m2, input logic [2:0] s,
                     input logic [7:0] c, input logic io, input logic ios);
    @(posedge clk_logic); #1;
    addr_strobe = 1'b1; addr = a; m2sel_n = m2; idle_slot_if();
    @(posedge clk_logic); #1;
    addr_strobe = 1'b0; slot = s; card_id = c; ioselect_n = io; iostrobe_n = ios;
    @(posedge clk_logic); #1;
    idle_slot_if();
  endtask

  // Behavioural reference: owner is a slot number or -1 for none
  int          m_own;
  logic [7:0]  m_card, m_sel;
  logic        m_pend, m_m2, m_cl, m_rl;
  logic [15:0] m_addr;

  task automatic model_step();
    logic cfg_hit, claim_ok;
    m_cl = 1'b0; m_rl = 1'b0;
    if (bus_reset) begin
      m_own = -1; m_card = 8'h00; m_sel = 8'hFF; m_pend = 1'b0;
      return;
    end
    if (m_pend) begin
      if (m_own >= 0 && !iostrobe_n) m_sel = 8'hFF - 8'(1 << m_own);
      else m_sel = 8'hFF;
    end
    cfg_hit = cfg_wr && (m_own >= 0) && (int'(cfg_slot) == m_own);
    if (cfg_hit) begin
      m_own = -1; m_card = 8'h00; m_rl = 1'b1;
    end
    claim_ok = m_pend && !ioselect_n && (card_id != 8'h00) && !(cfg_hit && slot == cfg_slot);
    if (claim_ok) begin
      if (m_own != int'(slot)) m_cl = 1'b1;
      m_own = int'(slot); m_card = card_id;
    end else if (m_pend && m_addr == 16'hCFFF && !m_m2 && m_own >= 0) begin
      m_own = -1; m_card = 8'h00; m_rl = 1'b1;
    end
    m_pend = addr_strobe;
    if (addr_strobe) begin
      m_addr = addr; m_m2 = m2sel_n;
    end
  endtask

  initial begin
    tbl[0]  = '{16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1, 1'b1, 3'd6, 8'd5, 8'hFF, 1'b1, 1'b0};
    tbl[1]  = '{16'hC800, 1'b0, 3'd6, 8'd5, 1'b1, 1'b0, 1'b1, 3'd6, 8'd5, 8'hBF, 1'b0, 1'b0};
    tbl[2]  = '{16'hCFFF, 1'b0, 3'd6, 8'd5, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'hBF, 1'b0, 1'b1};
    tbl[3]  = '{16'hC800, 1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b0, 1'b0};
    tbl[4]  = '{16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1, 1'b1, 3'd6, 8'd5, 8'hFF, 1'b1, 1'b0};
    tbl[5]  = '{16'hC300, 1'b0, 3'd3, 8'd2, 1'b0, 1'b1, 1'b1, 3'd3, 8'd2, 8'hFF, 1'b1, 1'b0};
    tbl[6]  = '{16'hC300, 1'b0, 3'd3, 8'd2, 1'b0, 1'b1, 1'b1, 3'd3, 8'd2, 8'hFF, 1'b0, 1'b0};
    tbl[7]  = '{16'hC800, 1'b0, 3'd3, 8'd2, 1'b1, 1'b0, 1'b1, 3'd3, 8'd2, 8'hF7, 1'b0, 1'b0};
    tbl[8]  = '{16'hCFFF, 1'b0, 3'd3, 8'd2, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b0, 1'b1};
    tbl[9]  = '{16'hC400, 1'b0, 3'd4, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{16'hC800, 1'b0, 3'd4, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b0, 1'b0};
    tbl[11] = '{16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1, 1'b1, 3'd6, 8'd5, 8'hFF, 1'b1, 1'b0};
    tbl[12] = '{16'hCFFF, 1'b1, 3'd6, 8'd5, 1'b1, 1'b0, 1'b1, 3'd6, 8'd5, 8'hBF, 1'b0, 1'b0};
    tbl[13] = '{16'hCFFF, 1'b0, 3'd6, 8'd5, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b0, 1'b1};

    #12;
    chk_all("reset", 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);
    system_reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].a, tbl[i].m2, tbl[i].s, tbl[i].c, tbl[i].io, tbl[i].ios);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ec,
              tbl[i].esel, tbl[i].ecl, tbl[i].erl);
    end

    // Claim pulse lasts one cycle only
    txn(16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1);
    chk("claim_first", {31'd0, claim_pulse}, 32'd1);
    @(posedge clk_logic); #1;
    chk("claim_one_cycle", {31'd0, claim_pulse}, 32'd0);

    // Reconfiguring a different slot leaves ownership alone
    cfg_wr = 1'b1; cfg_slot = 3'd2;
    @(posedge clk_logic); #1;
    cfg_wr = 1'b0;
    chk_all("cfg_other", 1'b1, 3'd6, 8'd5, 8'hFF, 1'b0, 1'b0);
    cfg_wr = 1'b1; cfg_slot = 3'd6;
    @(posedge clk_logic); #1;
    cfg_wr = 1'b0;
    chk_all("cfg_owner", 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b1);
    @(posedge clk_logic); #1;
    chk("cfg_pulse_one_cycle", {31'd0, release_pulse}, 32'd0);

    // bus_reset while owning (c8_sel_n active) drops owner silently
    txn(16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1);
    txn(16'hC800, 1'b0, 3'd6, 8'd5, 1'b1, 1'b0);
    chk("pre_busreset_sel", {24'd0, c8_sel_n}, 32'h0000_00BF);
    bus_reset = 1'b1;
    @(posedge clk_logic); #1;
    bus_reset = 1'b0;
    chk_all("bus_reset", 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);

    // bus_reset cancels a pending sample: the following claim inputs are ignored
    @(posedge clk_logic); #1;
    addr_strobe = 1'b1; addr = 16'hC200; m2sel_n = 1'b0; bus_reset = 1'b1;
    @(posedge clk_logic); #1;
    addr_strobe = 1'b0; bus_reset = 1'b1;
    @(posedge clk_logic); #1;
    bus_reset = 1'b0;
    chk("bus_reset_cancel", {31'd0, owner_valid}, 32'd0);

    // system_reset_n dropped between strobe and sample
    txn(16'hC600, 1'b0, 3'd6, 8'd5, 1'b0, 1'b1);
    @(posedge clk_logic); #1;
    addr_strobe = 1'b1; addr = 16'hC500; m2sel_n = 1'b0;
    @(posedge clk_logic); #1;
    addr_strobe = 1'b0; slot = 3'd5; card_id = 8'd7; ioselect_n = 1'b0;
    #2 system_reset_n = 1'b0;
    #1;
    chk_all("sysrst_async", 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);
    #2 system_reset_n = 1'b1;
    @(posedge clk_logic); #1;
    idle_slot_if();
    chk_all("sysrst_no_claim", 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);

    // Randomized traffic against the model
    bus_reset = 1'b1;
    @(posedge clk_logic); #1;
    bus_reset = 1'b0;
    m_own = -1; m_card = 8'h00; m_sel = 8'hFF; m_pend = 1'b0;
    m_addr = 16'h0000; m_m2 = 1'b1; m_cl = 1'b0; m_rl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      addr_strobe = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0: addr = 16'hC000 | 16'($urandom_range(0, 7) << 8);
        1: addr = 16'hCFFF;
        2: addr = 16'hC800 | 16'($urandom_range(0, 16'h07FE));
        default: addr = 16'($urandom);
      endcase
      m2sel_n    = ($urandom_range(0, 4) == 0);
      slot       = 3'($urandom_range(0, 7));
      card_id    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      ioselect_n = ($urandom_range(0, 2) != 0);
      iostrobe_n = ($urandom_range(0, 1) == 0);
      cfg_wr     = ($urandom_range(0, 15) == 0);
      cfg_slot   = (m_own >= 0 && $urandom_range(0, 1) == 0) ? 3'(m_own) : 3'($urandom_range(0, 7));
      bus_reset  = ($urandom_range(0, 59) == 0);
      model_step();
      @(posedge clk_logic); #1;
      chk_all($sformatf("rand%0d", n), (m_own >= 0), (m_own >= 0) ? 3'(m_own) : 3'd0,
              m_card, m_sel, m_cl, m_rl);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/slot_c8_arbiter.md
# slot_c8_arbiter

Tracks which virtual slot owns the shared $C800–$CFFF expansion ROM window and produces a per-slot, owner-qualified I/O-strobe. Sits directly downstream of `slotmaker`. It consumes the registered `slot_if` selects and the Apple II bus address, and implements the standard claim/release protocol: a card claims the window on its $Cn00 access and releases it on a $CFFF access. Card models use `c8_sel_n[n]` in place of the global `iostrobe_n`.

## Interface
Parameters:
- `RELEASE_ADDR`, default 16'hCFFF: address whose access releases C8 ownership.

Ports (one clock; reset is asynchronous and active-low):
- `clk_logic`  in  1  logic clock (same clock as `slotmaker`).
- `system_reset_n`  in  1  asynchronous active-low reset.
- `addr_strobe`  in  1  one-cycle pulse: `addr` and `m2sel_n` valid this cycle (cycle T).
- `addr`  in  16  bus address.
- `m2sel_n`  in  1  bus I/O-region select, active low.
- `bus_reset`  in  1  synchronous Apple II RESET, active high.
- `slot`  in  3  from `slotmaker` `slot_if.slot`.
- `card_id`  in  8  from `slot_if.card_id`.
- `ioselect_n`  in  1  from `slot_if.ioselect_n`.
- `iostrobe_n`  in  1  from `slot_if.iostrobe_n`.
- `cfg_wr`  in  1  slot configuration write (same strobe driven to `slotmaker`).
- `cfg_slot`  in  3  slot being reconfigured.
- `owner_valid`  out  1  a slot currently owns C8 space.
- `owner_slot`  out  3  owning slot (0 when `owner_valid`=0).
- `owner_card`  out  8  card_id captured at claim (0 when not valid).
- `c8_sel_n`  out  8  per-slot C8 strobe, active low.
- `claim_pulse`  out  1  one-cycle pulse on ownership change to a new slot.
- `release_pulse`  out  1  one-cycle pulse when ownership is dropped.

## Operation
- At the `addr_strobe` cycle, latch `addr` and `m2sel_n`, and set `sample` (delayed strobe) for the next cycle. `slotmaker` outputs lag the address by one cycle, so all `slot_if` inputs are evaluated only in the `sample` cycle (T+1).
- States: IDLE (no owner) and OWNED(s, card).
- Claim: in a sample cycle with `ioselect_n`=0 and `card_id`≠0:
  - set `owner_slot`=`slot` and `owner_card`=`card_id`, and go to OWNED.
  - Pulse `claim_pulse` only if the state was IDLE or the owner was a different slot. Re-access by the same owner refreshes `owner_card` with no pulse.
  - `ioselect_n`=0 with `card_id`=0 is ignored.
- Strobe: in a sample cycle, `c8_sel_n[owner_slot]`=0 iff OWNED and `iostrobe_n`=0; all other bits are 1. The value is evaluated with the pre-update owner.
- Release: in a sample cycle where latched `addr`==`RELEASE_ADDR` and latched `m2sel_n`=0:
  - the access is still strobed to the current owner, per the strobe rule;
  - then go to IDLE and pulse `release_pulse` if the state was OWNED.
  - Release does not depend on `iostrobe_n`, so INTC8ROM-gated $CFFF accesses still release.
- `cfg_wr` with `cfg_slot`==`owner_slot` while OWNED: go to IDLE and pulse `release_pulse`. This is evaluated every cycle, not only in sample cycles, and takes priority over a same-cycle claim by that slot.
- `bus_reset`=1: go to IDLE, set `c8_sel_n`=8'hFF, and cancel a pending `sample`. No `release_pulse`. It has priority over all other events.
- Claim and release cannot coincide, because they come from disjoint addresses. If `addr_strobe` and `sample` coincide, both are handled: the latch updates and the old sample is evaluated.

## Timing
- Address at cycle T, evaluation at T+1, outputs registered and visible at T+2.
- `c8_sel_n` holds its value until the next sample cycle and then updates. It is forced to 8'hFF at T+2 of any sample cycle with `iostrobe_n`=1.
- `claim_pulse` and `release_pulse` are high for exactly one cycle (T+2, or one cycle after `cfg_wr`).
- Reset values: `owner_valid`=0, `owner_slot`=0, `owner_card`=0, `c8_sel_n`=8'hFF, both pulses 0, `sample`=0, latched address 0, `m2sel_n` latch 1.
- Asserting `system_reset_n` mid-transaction drops any in-flight sample; there are no outputs until the first new `addr_strobe` plus 2 cycles.

## Test plan
- Claim then strobe: access $C600 (slot 6, card 5, `ioselect_n`=0), then $C800 with `iostrobe_n`=0 → T+2 `claim_pulse`=1, `owner_slot`=6, `owner_card`=5; then `c8_sel_n`=8'hBF.
- Release: with slot 6 owning, access $CFFF with `iostrobe_n`=0 → `c8_sel_n`=8'hBF at T+2 and `release_pulse`=1, `owner_valid`=0; next $C800 access → `c8_sel_n`=8'hFF.
- Ownership handoff and same-owner re-access: $C600, $C300 (card 2), $C300 → one `claim_pulse` at each of the first two accesses, none at the third; final `owner_slot`=3, `owner_card`=2.
- Disabled card: $C400 with `card_id`=0 while IDLE → stays IDLE, no pulse, `c8_sel_n`=8'hFF.
- Reconfigure owner: slot 6 owns; `cfg_wr`, `cfg_slot`=6 → next cycle `release_pulse`=1, `owner_valid`=0. `cfg_slot`=2 instead → no change.
- Resets: `bus_reset` while owning → IDLE with no `release_pulse`. Drop `system_reset_n` between `addr_strobe` and sample → all outputs at reset values and no claim from the dropped cycle.
